// File: rtl/siso_rowunit_gen.sv
// Pipelined layered min-sum SISO row unit: compressed E-memory, write-first bypass and RAW hazard stall.
// Optional macro SISO_EMEM_CLEAR_EN: zero every E-memory entry after reset before accepting work.
module siso_rowunit_gen #(
    parameter int WC        = 32,
    parameter int W         = 6,
    parameter int WCBITS    = 5,
    parameter int LAYERS    = 2,
    parameter int LAYERBITS = 1,
    parameter int ADDRWIDTH = 5,
    parameter int ADDRDEPTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LAYERBITS-1:0] in_layer,
    input  logic [ADDRWIDTH-1:0] in_addr,
    input  logic                 in_first_iter,
    input  logic [WC*W-1:0]      in_llr,
    output logic                 out_valid,
    output logic [LAYERBITS-1:0] out_layer,
    output logic [ADDRWIDTH-1:0] out_addr,
    output logic [WC*W-1:0]      out_llr,
    output logic [WC*W-1:0]      out_d
);

    localparam int MW    = W - 1;
    localparam int EW    = 2 * MW + WCBITS + WC;
    localparam int DEPTH = LAYERS * ADDRDEPTH;
    localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic signed [W:0] POS = (W+1)'(2 ** (W - 1) - 1);
    localparam logic signed [W:0] NEG = -POS;

    // Symmetric saturation keeps -2^(W-1) out of the datapath so negation is always safe.
    function automatic logic [W-1:0] sat(input logic signed [W:0] x);
        logic [W-1:0] r;
        if (x > POS)
            r = POS[W-1:0];
        else if (x < NEG)
            r = NEG[W-1:0];
        else
            r = x[W-1:0];
        return r;
    endfunction

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] s;
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        return sat(s);
    endfunction

    function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] s;
        s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        return sat(s);
    endfunction

    function automatic logic [W-1:0] recover(input logic [MW-1:0] m1, input logic [MW-1:0] m2,
                                             input logic [WCBITS-1:0] idx, input logic sgn,
                                             input int lane);
        logic [W-1:0] mag;
        mag = (WCBITS'(lane) == idx) ? {1'b0, m2} : {1'b0, m1};
        return sgn ? -mag : mag;
    endfunction

    logic              ready_q;
    logic              hazard;
    logic              accept;
    logic              in_range_in;
    logic [IDXW-1:0]   rd_idx;

    logic [EW-1:0]     emem [DEPTH];
    logic [EW-1:0]     e_rd_q;
    logic              e_we;
    logic [IDXW-1:0]   e_waddr;
    logic [EW-1:0]     e_wdata;
    logic [MW-1:0]     e_min1, e_min2;
    logic [WCBITS-1:0] e_idx;
    logic [WC-1:0]     e_sgn;

    logic                 s1_valid, s2_valid, s3_valid, s4_valid;
    logic [LAYERBITS-1:0] s1_layer, s2_layer, s3_layer, s4_layer;
    logic [ADDRWIDTH-1:0] s1_addr, s2_addr, s3_addr, s4_addr;
    logic                 s1_in_range, s2_in_range, s3_in_range, s4_in_range;
    logic [IDXW-1:0]      s1_eidx, s2_eidx, s3_eidx, s4_eidx;
    logic                 s1_use_old;
    logic [WC*W-1:0]      s1_llr;
    logic [WC*W-1:0]      s2_q, s3_q, s4_q;
    logic [WC*W-1:0]      s2_rold, s3_rold, s4_rold;
    logic [WC*MW-1:0]     s3_abs;
    logic [WC-1:0]        s3_qsgn, s4_qsgn;
    logic [MW-1:0]        s4_min1, s4_min2;
    logic [WCBITS-1:0]    s4_idx;
    logic                 s4_par;

    logic [WC*W-1:0]      c1_rold, c1_q;
    logic [WC*MW-1:0]     c2_abs;
    logic [WC-1:0]        c2_qsgn;
    logic [MW-1:0]        c3_min1, c3_min2;
    logic [WCBITS-1:0]    c3_idx;
    logic                 c3_par;
    logic [WC-1:0]        c4_sgn;
    logic [WC*W-1:0]      c4_rnew, c4_llr, c4_d;

    always_comb begin
        in_range_in = (int'(in_layer) < LAYERS) && (int'(in_addr) < ADDRDEPTH);
        rd_idx      = '0;
        if (in_range_in)
            rd_idx = IDXW'(int'(in_layer) * ADDRDEPTH + int'(in_addr));
    end

    // C4 is excluded from the hazard check: its write lands on the same edge as the new read.
    always_comb begin
        hazard = (s1_valid && s1_layer == in_layer && s1_addr == in_addr) ||
                 (s2_valid && s2_layer == in_layer && s2_addr == in_addr) ||
                 (s3_valid && s3_layer == in_layer && s3_addr == in_addr);
    end

    assign in_ready = ready_q && !rst && !hazard;
    assign accept   = in_valid && in_ready;

`ifdef SISO_EMEM_CLEAR_EN
    typedef enum logic {ST_SWEEP, ST_RUN} state_t;
    state_t          state;
    logic [IDXW-1:0] sweep_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SWEEP;
            sweep_idx <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    if (sweep_idx == IDXW'(DEPTH - 1)) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    always_comb begin
        e_we    = s4_valid && s4_in_range && !rst;
        e_waddr = s4_eidx;
        e_wdata = {s4_min1, s4_min2, s4_idx, c4_sgn};
        if (state == ST_SWEEP && !rst) begin
            e_we    = 1'b1;
            e_waddr = sweep_idx;
            e_wdata = '0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            ready_q <= 1'b0;
        else
            ready_q <= 1'b1;
    end

    always_comb begin
        e_we    = s4_valid && s4_in_range && !rst;
        e_waddr = s4_eidx;
        e_wdata = {s4_min1, s4_min2, s4_idx, c4_sgn};
    end
`endif

    always_ff @(posedge clk) begin
        if (e_we)
            emem[e_waddr] <= e_wdata;
    end

    // Write-first: a read colliding with the C4 write sees the freshly computed entry.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (e_we && e_waddr == rd_idx)
                e_rd_q <= e_wdata;
            else
                e_rd_q <= emem[rd_idx];
        end
    end

    assign e_min1 = e_rd_q[EW-1 -: MW];
    assign e_min2 = e_rd_q[WC+WCBITS +: MW];
    assign e_idx  = e_rd_q[WC +: WCBITS];
    assign e_sgn  = e_rd_q[WC-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s4_valid <= s3_valid;
        end
    end

    always_ff @(posedge clk) begin
        s1_layer    <= in_layer;
        s1_addr     <= in_addr;
        s1_in_range <= in_range_in;
        s1_eidx     <= rd_idx;
        s1_use_old  <= !in_first_iter && in_range_in;
        s1_llr      <= in_llr;

        s2_layer    <= s1_layer;
        s2_addr     <= s1_addr;
        s2_in_range <= s1_in_range;
        s2_eidx     <= s1_eidx;
        s2_q        <= c1_q;
        s2_rold     <= c1_rold;

        s3_layer    <= s2_layer;
        s3_addr     <= s2_addr;
        s3_in_range <= s2_in_range;
        s3_eidx     <= s2_eidx;
        s3_q        <= s2_q;
        s3_rold     <= s2_rold;
        s3_abs      <= c2_abs;
        s3_qsgn     <= c2_qsgn;

        s4_layer    <= s3_layer;
        s4_addr     <= s3_addr;
        s4_in_range <= s3_in_range;
        s4_eidx     <= s3_eidx;
        s4_q        <= s3_q;
        s4_rold     <= s3_rold;
        s4_qsgn     <= s3_qsgn;
        s4_min1     <= c3_min1;
        s4_min2     <= c3_min2;
        s4_idx      <= c3_idx;
        s4_par      <= c3_par;
    end

    always_comb begin
        c1_rold = '0;
        c1_q    = '0;
        for (int i = 0; i < WC; i++) begin
            if (s1_use_old)
                c1_rold[i*W +: W] = recover(e_min1, e_min2, e_idx, e_sgn[i], i);
            c1_q[i*W +: W] = sat_sub(s1_llr[i*W +: W], c1_rold[i*W +: W]);
        end
    end

    always_comb begin
        c2_abs  = '0;
        c2_qsgn = '0;
        for (int i = 0; i < WC; i++) begin
            c2_qsgn[i] = s2_q[i*W + W - 1];
            if (c2_qsgn[i])
                c2_abs[i*MW +: MW] = MW'(-s2_q[i*W +: W]);
            else
                c2_abs[i*MW +: MW] = s2_q[i*W +: MW];
        end
    end

    // Strict less-than keeps the lowest lane on ties; min2 skips only the chosen lane.
    always_comb begin
        c3_min1 = '1;
        c3_min2 = '1;
        c3_idx  = '0;
        for (int i = 0; i < WC; i++) begin
            if (s3_abs[i*MW +: MW] < c3_min1) begin
                c3_min1 = s3_abs[i*MW +: MW];
                c3_idx  = WCBITS'(i);
            end
        end
        for (int i = 0; i < WC; i++) begin
            if (WCBITS'(i) != c3_idx && s3_abs[i*MW +: MW] < c3_min2)
                c3_min2 = s3_abs[i*MW +: MW];
        end
        c3_par = ^s3_qsgn;
    end

    always_comb begin
        c4_sgn  = s4_qsgn ^ {WC{s4_par}};
        c4_rnew = '0;
        c4_llr  = '0;
        c4_d    = '0;
        for (int i = 0; i < WC; i++) begin
            c4_rnew[i*W +: W] = recover(s4_min1, s4_min2, s4_idx, c4_sgn[i], i);
            c4_llr[i*W +: W]  = sat_add(s4_q[i*W +: W], c4_rnew[i*W +: W]);
            c4_d[i*W +: W]    = sat_sub(c4_rnew[i*W +: W], s4_rold[i*W +: W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !s4_valid) begin
            out_valid <= 1'b0;
            out_layer <= '0;
            out_addr  <= '0;
            out_llr   <= '0;
            out_d     <= '0;
        end else begin
            out_valid <= 1'b1;
            out_layer <= s4_layer;
            out_addr  <= s4_addr;
            out_llr   <= c4_llr;
            out_d     <= c4_d;
        end
    end

endmodule

// File: doc/siso_rowunit_gen.md
# siso_rowunit_gen

Parametrised, handshaked successor of the layered min-sum SISO row unit. It processes one row slice per accepted transaction: WC lanes of LLRs in, updated LLRs and extrinsic deltas out. It has an integrated compressed E-memory indexed by {layer, address} and read-after-write hazard stalling. It sits between the L-memory read port and the L-memory write-back/D-reaccess path of the decoder top.

## Interface
- WC, 32, lanes per slice
- W, 6, LLR width (two's complement)
- WCBITS, 5, index width, 2^WCBITS >= WC
- LAYERS, 2, layer count
- LAYERBITS, 1, layer field width
- ADDRWIDTH, 5, address field width
- ADDRDEPTH, 20, valid addresses per layer (0..ADDRDEPTH-1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  transaction present
- in_ready  out  1  block accepts this cycle
- in_layer  in  LAYERBITS  layer of slice
- in_addr  in  ADDRWIDTH  row address within layer
- in_first_iter  in  1  force R_old = 0 (E entry ignored)
- in_llr  in  WC*W  lane i at [i*W +: W]
- out_valid  out  1  one-cycle result strobe
- out_layer  out  LAYERBITS  echoed layer
- out_addr  out  ADDRWIDTH  echoed address
- out_llr  out  WC*W  updated LLR per lane
- out_d  out  WC*W  R_new - R_old per lane

## Operation
- E entry format: {min1[W-1], min2[W-1], idx[WCBITS], sgn[WC]}, width 2*(W-1)+WCBITS+WC. Depth LAYERS*ADDRDEPTH, index in_layer*ADDRDEPTH+in_addr. Contents are not reset.
- Recover: R_i = (sgn_i ? -1 : +1) * (i==idx ? min2 : min1).
- Q_i = sat(L_i - R_old_i).
- sat() is symmetric to [-(2^(W-1)-1), +(2^(W-1)-1)] and uses a W+1-bit intermediate.
- min1 = min|Q|, idx = lowest lane achieving min1, min2 = min over lanes != idx (equal minima give min2 = min1).
- P = XOR of Q sign bits. New sgn_i = P XOR sign(Q_i).
- out_llr_i = sat(Q_i + R_new_i); out_d_i = sat(R_new_i - R_old_i).
- Out-of-range (in_layer >= LAYERS or in_addr >= ADDRDEPTH):
  - the transaction is accepted and R_old = 0;
  - no E write occurs;
  - out_valid is still pulsed.
- Hazard: in_ready = 0 while any in-flight transaction in stages C1..C3 has the same {layer, addr} as the input. Matching against C4 is allowed because the E memory is write-first.
- No output backpressure. The downstream consumer must take every out_valid pulse.

## Timing
- C0: in_valid && in_ready. At the end of C0 the inputs are captured and the E read is issued.
- C1: R_old is available and Q is registered at the end of the cycle.
- C2: |Q| and the signs are registered.
- C3: min1, min2, idx and P are registered.
- C4: R_new, out_llr and out_d are computed. Output registers and the E write both update at the end of C4.
- C5: out_valid = 1. Latency is 5 cycles and the pipeline is fully pipelined: throughput is 1 per cycle absent hazards.
- A same-entry read at the write edge returns the new data.
- Reset values:
  - in_ready = 0 during rst, then 1 from the cycle after rst deasserts (macro off).
  - out_valid, out_layer, out_addr, out_llr and out_d are all 0.
- Outputs return to 0 in cycles without out_valid.
- Reset mid-operation: all stage valids clear, no pending E writes complete and no out_valid follows. E contents are retained with the macro off.
- in_valid low: stages advance as bubbles and no E write occurs.

## Configuration
- SISO_EMEM_CLEAR_EN
  - Defined: after rst deasserts, the block sweeps all LAYERS*ADDRDEPTH entries writing zero, one per cycle, with in_ready = 0 throughout. in_ready rises the cycle after the last write. A rst during the sweep restarts it.
  - Undefined: no sweep. First-iteration correctness relies on in_first_iter.

## Test plan
Parameters for these scenarios: WC=4, W=6, WCBITS=2, LAYERS=2, ADDRDEPTH=4, listed lanes 0..3.
- First-iteration update:
  - Stimulus: layer 0, addr 1, in_first_iter=1, L={10,-3,7,20}.
  - Expected: out_valid 5 cycles after acceptance, out_llr={7,4,4,17}, out_d={-3,7,-3,-3}.
  - Expected E entry: min1=3, min2=7, idx=1, sgn={1,0,1,1}.
- Second pass on the same entry:
  - Stimulus: L={7,4,4,17}, in_first_iter=0, issued 10 cycles later.
  - Expected: out_llr={7,4,4,17}, out_d={0,0,0,0}.
- Hazard stall:
  - Stimulus: the same {layer, addr} presented on back-to-back cycles.
  - Expected: first accepted at cycle 0, in_ready=0 at cycles 1..3, second accepted at cycle 4, and the second sees the updated E.
  - Also: different addresses back-to-back are accepted every cycle, and out_valid is held high for N consecutive cycles.
- Saturation:
  - Stimulus: in_first_iter=1, L={31,31,31,31}.
  - Expected: min1=min2=31, out_llr={31,31,31,31} (clipped from 62), out_d={31,31,31,31}.
  - Also: an input of -32 saturates Q to -31.
- Reset and out-of-range:
  - rst asserted with 3 transactions in flight: no out_valid afterwards and all outputs are 0.
  - Stimulus: addr=5 (out of range).
  - Expected: out_valid with R_old=0 and no E write; a later read of entries 0..7 is unchanged.
- Macro on:
  - Expected after rst: in_ready=0 for exactly 8 cycles, and every entry then reads zero with in_first_iter=0.
